ltssm_sequencer: RTL and testbench

Top-level LTSSM sequencer for the PCIe PHY. It drives the shared `substate` code to the master RX and TX LTSSM sub-FSMs and collects each side's `finish`/`exitTo` handshake. It advances to the next substate only when both sides agree, and falls back to `detectQuiet` on any failure, disagreement or forced retrain. It also latches the detected lane count and reports link status on the LPIF `lpifStatus` bus.

---
 rtl/ltssm_pkg.sv | 33 +++
 rtl/ltssm_finish_collect.sv | 66 ++++++
 rtl/ltssm_sequencer.sv | 150 +++++++++++++++
 tb/tb_ltssm_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ltssm_pkg.sv
// rtl/ltssm_pkg.sv - shared LTSSM substate codes, LPIF status codes and sequencer state encoding
// Purpose: single source of the substate numbering used by the sequencer and the RX/TX LTSSMs.
// Ports: none (package).
package ltssm_pkg;

  // Substate codes in LTSSM order; PARK is the "no request" code shown between requests.
  localparam logic [3:0] detectQuiet          = 4'd0;
  localparam logic [3:0] detectActive         = 4'd1;
  localparam logic [3:0] pollingActive        = 4'd2;
  localparam logic [3:0] pollingConfiguration = 4'd3;
  localparam logic [3:0] configLinkwidthStart = 4'd4;
  localparam logic [3:0] configLinkwidthAccept= 4'd5;
  localparam logic [3:0] configLanenumWait    = 4'd6;
  localparam logic [3:0] configLanenumAccept  = 4'd7;
  localparam logic [3:0] configComplete       = 4'd8;
  localparam logic [3:0] configIdle           = 4'd9;
  localparam logic [3:0] L0                   = 4'd10;
  localparam logic [3:0] PARK                 = 4'hF;

  // LPIF link status codes.
  localparam logic [3:0] lpifReset     = 4'h0;
  localparam logic [3:0] lpifActive    = 4'h1;
  localparam logic [3:0] lpifLinkError = 4'hA;
  localparam logic [3:0] lpifRetrain   = 4'hB;

  // Sequencer states. HOLD_ERR is only reachable with LTSSM_FAIL_LIMIT_EN.
  typedef enum logic [1:0] {
    PARK_S   = 2'd0,
    RUN_S    = 2'd1,
    HOLD_ERR = 2'd2
  } seqState_t;

endpackage

// File: rtl/ltssm_finish_collect.sv
// rtl/ltssm_finish_collect.sv - sticky RX/TX finish collector with exitTo agreement check
// Purpose: remembers the first finish/exitTo of each side until cleared and judges the pair.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   clear                 drop and forget finishes (held while the sequencer is not running)
//   rxFinish, rxExitTo    RX handshake
//   txFinish, txExitTo    TX handshake
//   cur                   substate currently requested
//   bothDone              both sides have finished (including finishes arriving this cycle)
//   agree                 both captured exitTo values are equal
//   nextOk                RX exitTo is the successor of cur and cur is below L0
module ltssm_finish_collect
  import ltssm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       rxFinish,
  input  logic [3:0] rxExitTo,
  input  logic       txFinish,
  input  logic [3:0] txExitTo,
  input  logic [3:0] cur,
  output logic       bothDone,
  output logic       agree,
  output logic       nextOk
);

  logic       rxDone, txDone;
  logic [3:0] rxExitQ, txExitQ;
  logic       rxSeen, txSeen;
  logic [3:0] rxExit, txExit;

  // First finish per side wins; later pulses are ignored until clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxDone  <= 1'b0;
      txDone  <= 1'b0;
      rxExitQ <= detectQuiet;
      txExitQ <= detectQuiet;
    end else if (clear) begin
      rxDone <= 1'b0;
      txDone <= 1'b0;
    end else begin
      if (rxFinish && !rxDone) begin
        rxDone  <= 1'b1;
        rxExitQ <= rxExitTo;
      end
      if (txFinish && !txDone) begin
        txDone  <= 1'b1;
        txExitQ <= txExitTo;
      end
    end
  end

  // Merge this cycle's pulse so the decision lands on the edge sampling the later finish.
  always_comb begin
    rxSeen   = rxDone | (rxFinish & ~clear);
    txSeen   = txDone | (txFinish & ~clear);
    rxExit   = rxDone ? rxExitQ : rxExitTo;
    txExit   = txDone ? txExitQ : txExitTo;
    bothDone = rxSeen & txSeen;
    agree    = (rxExit == txExit);
    nextOk   = (cur < L0) && (rxExit == cur + 4'd1);
  end

endmodule

// File: rtl/ltssm_sequencer.sv
// rtl/ltssm_sequencer.sv - top-level LTSSM sequencer driving the shared substate to RX/TX LTSSMs
// Purpose: steps the link through substates when RX and TX agree, parks between requests,
//   falls back to detectQuiet on failure or retrain, latches lane count, reports LPIF status.
// Optional feature macro: LTSSM_FAIL_LIMIT_EN (consecutive-failure limit and HOLD_ERR state).
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   rxFinish, rxExitTo         RX LTSSM handshake
//   txFinish, txExitTo         TX LTSSM handshake
//   detectedLanesIn            lane count from receiver detect
//   forceDetect                level retrain request
//   substate                   requested substate (PARK between requests)
//   numberOfDetectedLanes      latched, saturated lane count
//   linkUp                     high while substate is L0
//   lpifStatus                 LPIF state code
module ltssm_sequencer
  import ltssm_pkg::*;
#(
  parameter int MAXLANES = 16
`ifdef LTSSM_FAIL_LIMIT_EN
  , parameter int MAX_FAILS = 4
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxFinish,
  input  logic [3:0] rxExitTo,
  input  logic       txFinish,
  input  logic [3:0] txExitTo,
  input  logic [4:0] detectedLanesIn,
  input  logic       forceDetect,
  output logic [3:0] substate,
  output logic [4:0] numberOfDetectedLanes,
  output logic       linkUp,
  output logic [3:0] lpifStatus
);

  seqState_t  state, stateNext;
  logic [3:0] target, targetNext;
  logic       retrain, retrainNext;
  logic [4:0] lanesNext, lanesSat;
  logic [3:0] substateNext, lpifNext;
  logic       linkUpNext;
  logic       bothDone, agree, nextOk;
`ifdef LTSSM_FAIL_LIMIT_EN
  logic [2:0] failCnt, failNext;
`endif

  ltssm_finish_collect uCollect (
    .clk      (clk),
    .reset    (reset),
    .clear    (state != RUN_S),
    .rxFinish (rxFinish),
    .rxExitTo (rxExitTo),
    .txFinish (txFinish),
    .txExitTo (txExitTo),
    .cur      (target),
    .bothDone (bothDone),
    .agree    (agree),
    .nextOk   (nextOk)
  );

  assign lanesSat = (int'(detectedLanesIn) > MAXLANES) ? 5'(MAXLANES) : detectedLanesIn;

  // State and output registers. Outputs are decoded from the current state, so they
  // trail the internal state by one edge (PARK shows one cycle after the decision).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= PARK_S;
      target                <= detectQuiet;
      retrain               <= 1'b0;
      numberOfDetectedLanes <= 5'd0;
      substate              <= PARK;
      linkUp                <= 1'b0;
      lpifStatus            <= lpifReset;
`ifdef LTSSM_FAIL_LIMIT_EN
      failCnt               <= 3'd0;
`endif
    end else begin
      state                 <= stateNext;
      target                <= targetNext;
      retrain               <= retrainNext;
      numberOfDetectedLanes <= lanesNext;
      substate              <= substateNext;
      linkUp                <= linkUpNext;
      lpifStatus            <= lpifNext;
`ifdef LTSSM_FAIL_LIMIT_EN
      failCnt               <= failNext;
`endif
    end
  end

  // Next-state logic. forceDetect is checked before any decision so it wins ties.
  always_comb begin
    stateNext   = state;
    targetNext  = target;
    retrainNext = retrain;
    lanesNext   = numberOfDetectedLanes;
`ifdef LTSSM_FAIL_LIMIT_EN
    failNext    = failCnt;
`endif
    case (state)
      PARK_S: stateNext = RUN_S;
      RUN_S: begin
        if (forceDetect) begin
          stateNext  = PARK_S;
          targetNext = detectQuiet;
          if (target == L0) retrainNext = 1'b1;
        end else if (target == L0) begin
          retrainNext = 1'b0;
        end else if (bothDone) begin
          stateNext = PARK_S;
          if (agree && nextOk) begin
            targetNext = target + 4'd1;
            if (target == detectActive) lanesNext = lanesSat;
`ifdef LTSSM_FAIL_LIMIT_EN
            failNext = 3'd0;
`endif
          end else begin
            targetNext = detectQuiet;
`ifdef LTSSM_FAIL_LIMIT_EN
            failNext = (failCnt == 3'd7) ? failCnt : failCnt + 3'd1;
            if (int'(failNext) >= MAX_FAILS) stateNext = HOLD_ERR;
`endif
          end
        end
      end
      HOLD_ERR: begin
        if (forceDetect) begin
          stateNext  = PARK_S;
          targetNext = detectQuiet;
`ifdef LTSSM_FAIL_LIMIT_EN
          failNext   = 3'd0;
`endif
        end
      end
      default: stateNext = PARK_S;
    endcase
  end

  // Output decode.
  always_comb begin
    substateNext = (state == RUN_S) ? target : PARK;
    linkUpNext   = (state == RUN_S) && (target == L0);
    if (state == HOLD_ERR)  lpifNext = lpifLinkError;
    else if (linkUpNext)    lpifNext = lpifActive;
    else if (retrain)       lpifNext = lpifRetrain;
    else                    lpifNext = lpifReset;
  end

endmodule

// File: tb/tb_ltssm_sequencer.sv
// tb/tb_ltssm_sequencer.sv - self-checking bench for ltssm_sequencer with a behavioural link model
module tb_ltssm_sequencer;
  import ltssm_pkg::*;

  logic       clk;
  logic       reset;
  logic       rxFinish, txFinish, forceDetect;
  logic [3:0] rxExitTo, txExitTo;
  logic [4:0] detectedLanesIn;
  logic [3:0] substate, lpifStatus;
  logic [4:0] numberOfDetectedLanes;
  logic       linkUp;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: the substate the link should be in and the status it implies.
  logic [3:0] mSub;
  logic [4:0] mLanes;
  logic       mRetrain;
  logic       mHold;
  int         mFails;

  ltssm_sequencer dut (
    .clk                   (clk),
    .reset                 (reset),
    .rxFinish              (rxFinish),
    .rxExitTo              (rxExitTo),
    .txFinish              (txFinish),
    .txExitTo              (txExitTo),
    .detectedLanesIn       (detectedLanesIn),
    .forceDetect           (forceDetect),
    .substate              (substate),
    .numberOfDetectedLanes (numberOfDetectedLanes),
    .linkUp                (linkUp),
    .lpifStatus            (lpifStatus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutputs(input string tag);
    logic [3:0] eSub, eLpif;
    eSub  = mHold ? PARK : mSub;
    eLpif = mHold ? lpifLinkError : (mSub == L0) ? lpifActive : mRetrain ? lpifRetrain : lpifReset;
    checkVal({tag, ".substate"}, 8'(substate), 8'(eSub));
    checkVal({tag, ".linkUp"}, 8'(linkUp), 8'(!mHold && mSub == L0));
    checkVal({tag, ".lpif"}, 8'(lpifStatus), 8'(eLpif));
    checkVal({tag, ".lanes"}, 8'(numberOfDetectedLanes), 8'(mLanes));
  endtask

  // One handshake round: RX finishes at cycle rxDly (optionally again at rx2Dly), TX at txDly;
  // optional forceDetect on the cycle of the later finish.
  task automatic doStep(input int rxDly, input logic [3:0] rxX, input int txDly, input logic [3:0] txX,
                        input int rx2Dly, input logic [3:0] rx2X, input bit withForce,
                        input logic [4:0] lanesIn);
    int         last;
    logic       ok;
    logic [3:0] cur;
    cur  = mSub;
    last = (rxDly > txDly) ? rxDly : txDly;
    for (int c = 0; c <= last; c++) begin
      rxFinish        = (c == rxDly) || (c == rx2Dly);
      rxExitTo        = (c == rx2Dly) ? rx2X : ((c == rxDly) ? rxX : 4'($urandom));
      txFinish        = (c == txDly);
      txExitTo        = (c == txDly) ? txX : 4'($urandom);
      forceDetect     = withForce && (c == last);
      detectedLanesIn = lanesIn;
      tick();
    end
    rxFinish    = 1'b0;
    txFinish    = 1'b0;
    forceDetect = 1'b0;
    if (withForce) begin
      if (cur == L0) mRetrain = 1'b1;
      mSub = detectQuiet;
    end else begin
      ok = (rxX == txX) && (int'(rxX) == int'(cur) + 1) && (int'(cur) < 10);
      if (ok) begin
        if (cur == detectActive) mLanes = (lanesIn > 5'd16) ? 5'd16 : lanesIn;
        mSub   = 4'(int'(cur) + 1);
        mFails = 0;
        if (mSub == L0) mRetrain = 1'b0;
      end else begin
        mSub = detectQuiet;
`ifdef LTSSM_FAIL_LIMIT_EN
        if (mFails < 7) mFails++;
        if (mFails >= 4) mHold = 1'b1;
`endif
      end
    end
    tick();
    checkVal("step.park", 8'(substate), 8'(PARK));
    tick();
    checkOutputs("step");
  endtask

  task automatic doForce();
    forceDetect = 1'b1;
    tick();
    forceDetect = 1'b0;
    if (mHold) begin
      mHold  = 1'b0;
      mFails = 0;
    end else if (mSub == L0) begin
      mRetrain = 1'b1;
    end
    mSub = detectQuiet;
    tick();
    checkVal("force.park", 8'(substate), 8'(PARK));
    tick();
    checkOutputs("force");
  endtask

  task automatic walkTo(input logic [3:0] goal, input logic [4:0] lanesIn);
    logic [3:0] nx;
    for (int g = 0; g < 12 && mSub != goal; g++) begin
      nx = 4'(int'(mSub) + 1);
      doStep(int'($urandom_range(0, 3)), nx, int'($urandom_range(0, 3)), nx, -1, 4'd0, 1'b0, lanesIn);
    end
  endtask

  // Finishes while in L0 must not move the link.
  task automatic idleL0();
    for (int c = 0; c < 4; c++) begin
      rxFinish = (c < 2);
      txFinish = (c < 2);
      rxExitTo = 4'($urandom);
      txExitTo = rxExitTo;
      tick();
      checkVal("l0hold.substate", 8'(substate), 8'(L0));
    end
    rxFinish = 1'b0;
    txFinish = 1'b0;
  endtask

  initial begin
    int         r;
    logic [3:0] rxX, txX, nx;
    reset           = 1'b0;
    rxFinish        = 1'b0;
    txFinish        = 1'b0;
    rxExitTo        = 4'd0;
    txExitTo        = 4'd0;
    forceDetect     = 1'b0;
    detectedLanesIn = 5'd0;
    mSub     = detectQuiet;
    mLanes   = 5'd0;
    mRetrain = 1'b0;
    mHold    = 1'b0;
    mFails   = 0;

    repeat (3) tick();
    checkVal("reset.substate", 8'(substate), 8'(PARK));
    checkVal("reset.linkUp", 8'(linkUp), 8'd0);
    checkVal("reset.lpif", 8'(lpifStatus), 8'(lpifReset));
    checkVal("reset.lanes", 8'(numberOfDetectedLanes), 8'd0);
    reset = 1'b1;
    tick();
    checkVal("release.park", 8'(substate), 8'(PARK));
    tick();
    checkOutputs("release");

    walkTo(pollingActive, 5'd4);
    doStep(0, 4'd3, 1, 4'd0, -1, 4'd0, 1'b0, 5'd4);     // disagreement
    walkTo(pollingActive, 5'd4);
    doStep(0, 4'd3, 2, 4'd3, 1, 4'd0, 1'b0, 5'd4);      // second RX pulse ignored
    walkTo(L0, 5'd4);
    doForce();                                          // retrain from L0
    walkTo(L0, 5'd20);                                  // lane count saturates
    idleL0();
    doForce();
    walkTo(pollingConfiguration, 5'd7);
    doStep(0, 4'd4, 0, 4'd4, -1, 4'd0, 1'b1, 5'd7);     // force beats deciding finish
`ifdef LTSSM_FAIL_LIMIT_EN
    repeat (4) doStep(0, 4'd0, 1, 4'd0, -1, 4'd0, 1'b0, 5'd3);
    doForce();
`endif

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (mHold) begin
        doForce();
      end else if (mSub == L0) begin
        if (r < 50) doForce();
        else idleL0();
      end else if (r < 6) begin
        doForce();
      end else begin
        nx = 4'(int'(mSub) + 1);
        if (r < 88) begin
          rxX = nx;
          txX = nx;
        end else begin
          rxX = 4'($urandom_range(0, 15));
          txX = 4'($urandom_range(0, 15));
        end
        doStep(int'($urandom_range(0, 3)), rxX, int'($urandom_range(0, 3)), txX, -1, 4'd0,
               r >= 97, 5'($urandom_range(0, 31)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
